song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
Sequences the note player through a stored song. Fetches {note, duration} words from a synchronous song ROM and presents each note with a one-cycle load strobe. Waits for the player's note-done pulse, then advances to the next entry. Handles play/pause, song selection and end-of-song; sits between the top-level user controls and the note player.

Parameters:
NOTE_W, 6, note code width (0 = rest, passed through)
DUR_W, 6, duration width in beats (0 = end-of-song marker)
IDX_W, 5, note index width (32 entries per song)
SONG_W, 2, song select width (4 songs)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
play  in  1  level; 1 = play, 0 = pause
next_song  in  1  one-cycle pulse; select next song
rom_addr  out  SONG_W+IDX_W  registered {song, index} to song ROM
rom_data  in  NOTE_W+DUR_W  {note, duration}; valid 1 cycle after rom_addr
note_done  in  1  one-cycle pulse from note player
play_enable  out  1  enable to note player
note_to_load  out  NOTE_W  registered note; held between loads
duration_to_load  out  DUR_W  registered duration; held between loads
load_new_note  out  1  one-cycle load strobe
song_done  out  1  one-cycle pulse at end of song
current_song  out  SONG_W  selected song number

Behaviour:
- Reset: one clock, reset asynchronous and active-low. Asserting reset forces all state to defaults immediately, including mid-song. State is IDLE; song=0; index=0; rom_addr=0; note/duration=0; load_new_note, song_done and play_enable = 0.
- States: IDLE, FETCH, ROMWAIT, LOAD, PLAY, ADVANCE, END, STOPPED.
- play_enable = 1 in FETCH, ROMWAIT, LOAD, PLAY and ADVANCE; 0 otherwise.
- IDLE: if play=1, go to FETCH.
- FETCH: rom_addr <= {song, index}, then ROMWAIT.
- ROMWAIT: rom_data is valid in this cycle.
  - If duration field = 0, go to END.
  - Otherwise latch note and duration, then go to LOAD.
- LOAD: load_new_note=1 for exactly this cycle, then PLAY.
  - play_enable is high at least 2 cycles before load_new_note, so the player has left its reset state.
- PLAY: wait for note_done, then ADVANCE.
  - note_to_load and duration_to_load stay stable for the whole note.
- ADVANCE:
  - index=31: go to END.
  - Otherwise index <= index+1, then FETCH.
- END: song_done=1 for one cycle, index <= 0, then STOPPED.
- STOPPED: stays until play=0, then IDLE. Holding play high does not restart the song.
- Pause: play=0 in any of FETCH..ADVANCE goes to IDLE next cycle and drops play_enable. Index is retained. On resume the current note is refetched and replayed from its start.
- next_song:
  - Effect: song <= song+1 (wraps 3->0), index <= 0.
  - If playing: go to FETCH (no song_done). play_enable drops for one cycle to flush the player.
  - If in IDLE or STOPPED: apply the update and go to IDLE.
- Priority when events coincide:
  - reset > next_song > play=0 > note_done.
  - next_song in the same cycle as note_done: the note_done is discarded.
- Rest notes (note=0) are loaded normally.

Optional Feature:
SONG_LOOP_EN
- Defined: END still pulses song_done, but then goes to FETCH with index 0 and play_enable held high. The song repeats until pause or next_song. STOPPED is unreachable.
- Undefined: behaviour as above (stop at end).

Decomposition:
- Shared package holds: state encoding constants, NOTE_W/DUR_W/IDX_W/SONG_W defaults, and the END_MARK duration constant (0).
- One sub-module: song_index_counter.
  - Index and song registers with clear, increment and wrap.
  - Reports last-index (31) to the FSM.
  - FSM and output registers stay in song_sequencer.

Test Plan:
- Song 0 = {(12,2),(14,1),(0,0)}, play=1, player model pulses note_done -> load_new_note with note 12 dur 2, then note 14 dur 1. rom_addr 0,1,2, then song_done pulse, play_enable=0.
- 32 entries with no marker -> 32 loads, song_done after index 31, rom_addr never reaches 32.
- play=0 during the 2nd note of song 1 -> play_enable=0 next cycle. Resume -> rom_addr=0x21 refetched, note reloaded.
- next_song while song 3 is playing -> current_song=0, rom_addr=0x00, no song_done, one-cycle play_enable low.
- Reset asserted while in PLAY -> all outputs 0 asynchronously, state IDLE after release.
- SONG_LOOP_EN defined, 2-note song -> song_done pulse, then rom_addr returns to 0 with play_enable continuously high.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
// Shared widths, the end-of-song marker and the sequencer state encoding.
package song_sequencer_pkg;

    localparam int DEF_NOTE_W = 6;
    localparam int DEF_DUR_W  = 6;
    localparam int DEF_IDX_W  = 5;
    localparam int DEF_SONG_W = 2;

    // A zero duration field terminates a song.
    localparam logic [DEF_DUR_W-1:0] END_MARK = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_LOAD,
        S_PLAY,
        S_ADVANCE,
        S_END,
        S_STOPPED
    } state_e;

endpackage

// File: rtl/song_index_counter.sv
// Song and note-index registers. Selecting a new song restarts at index 0;
// next-state values are exported so the ROM address can be loaded early.
module song_index_counter #(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idx_clr_i,
    input  logic              idx_inc_i,
    input  logic              song_inc_i,
    output logic [SONG_W-1:0] song_o,
    output logic [IDX_W-1:0]  idx_nxt_o,
    output logic [SONG_W-1:0] song_nxt_o,
    output logic              idx_last_o
);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;

    always_comb begin
        idx_d  = idx_q;
        song_d = song_q;
        if (song_inc_i) begin
            song_d = song_q + 1'b1;
            idx_d  = '0;
        end else if (idx_clr_i) begin
            idx_d  = '0;
        end else if (idx_inc_i) begin
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            song_q <= '0;
        end else begin
            idx_q  <= idx_d;
            song_q <= song_d;
        end
    end

    assign song_o     = song_q;
    assign idx_nxt_o  = idx_d;
    assign song_nxt_o = song_d;
    assign idx_last_o = &idx_q;

endmodule

// File: rtl/song_sequencer.sv
// Steps the note player through {note, duration} words of the selected song.
// Define SONG_LOOP_EN to restart the song at its end instead of stopping.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int SONG_W = DEF_SONG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    next_song,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    input  logic                    note_done,
    output logic                    play_enable,
    output logic [NOTE_W-1:0]       note_to_load,
    output logic [DUR_W-1:0]        duration_to_load,
    output logic                    load_new_note,
    output logic                    song_done,
    output logic [SONG_W-1:0]       current_song
);

`ifdef SONG_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_e                  state_q;
    logic [SONG_W+IDX_W-1:0] rom_addr_q;
    logic [NOTE_W-1:0]       note_q;
    logic [DUR_W-1:0]        dur_q;
    logic                    load_q, done_q, pe_q, flush_q;

    logic [IDX_W-1:0]  idx_nxt;
    logic [SONG_W-1:0] song, song_nxt;
    logic              idx_last, playing, idx_inc, idx_clr;

    assign playing = state_q inside {S_FETCH, S_ROMWAIT, S_LOAD, S_PLAY, S_ADVANCE};
    assign idx_inc = (state_q == S_ADVANCE) && !idx_last && !next_song && play;
    assign idx_clr = (state_q == S_END);

    song_index_counter #(.IDX_W(IDX_W), .SONG_W(SONG_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .idx_clr_i  (idx_clr),
        .idx_inc_i  (idx_inc),
        .song_inc_i (next_song),
        .song_o     (song),
        .idx_nxt_o  (idx_nxt),
        .song_nxt_o (song_nxt),
        .idx_last_o (idx_last)
    );

    // rom_addr is loaded on entry to FETCH so the synchronous ROM word is
    // ready during ROMWAIT. A song change spends one extra FETCH cycle with
    // play_enable low to flush the player.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            pe_q       <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= 1'b0;
            if (next_song) begin
                pe_q <= 1'b0;
                if (playing) begin
                    state_q    <= S_FETCH;
                    flush_q    <= 1'b1;
                    rom_addr_q <= {song_nxt, idx_nxt};
                end else begin
                    state_q <= S_IDLE;
                end
            end else if (playing && !play) begin
                state_q <= S_IDLE;
                pe_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (play) begin
                        state_q    <= S_FETCH;
                        pe_q       <= 1'b1;
                        rom_addr_q <= {song_nxt, idx_nxt};
                    end
                    S_FETCH: begin
                        pe_q <= 1'b1;
                        if (!flush_q) state_q <= S_ROMWAIT;
                    end
                    S_ROMWAIT: begin
                        if (rom_data[DUR_W-1:0] == DUR_W'(END_MARK)) begin
                            state_q <= S_END;
                            done_q  <= 1'b1;
                            pe_q    <= LOOP_EN;
                        end else begin
                            note_q  <= rom_data[NOTE_W+DUR_W-1:DUR_W];
                            dur_q   <= rom_data[DUR_W-1:0];
                            load_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD:  state_q <= S_PLAY;
                    S_PLAY:  if (note_done) state_q <= S_ADVANCE;
                    S_ADVANCE: begin
                        if (idx_last) begin
                            state_q <= S_END;
                            done_q  <= 1'b1;
                            pe_q    <= LOOP_EN;
                        end else begin
                            state_q    <= S_FETCH;
                            rom_addr_q <= {song_nxt, idx_nxt};
                        end
                    end
                    S_END: begin
                        if (LOOP_EN) begin
                            state_q    <= S_FETCH;
                            pe_q       <= 1'b1;
                            rom_addr_q <= {song_nxt, idx_nxt};
                        end else begin
                            state_q <= S_STOPPED;
                            pe_q    <= 1'b0;
                        end
                    end
                    S_STOPPED: if (!play) state_q <= S_IDLE;
                    default:   state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rom_addr         = rom_addr_q;
    assign play_enable      = pe_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = load_q;
    assign song_done        = done_q;
    assign current_song     = song;

endmodule

// File: tb/tb_song_sequencer.sv
// Random song contents and player latency against an entry-list model of the
// expected note sequence, plus directed pause, song-change and reset steps.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset, play, next_song, note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic        play_enable, load_new_note, song_done;
    logic [5:0]  note_to_load, duration_to_load;
    logic [1:0]  current_song;

    logic [11:0] rom_mem [0:127];
    logic [1:0]  pe_h = 2'b00;
    int          sd_cnt = 0, ld_cnt = 0;
    int          vec = 0, errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];
    always @(posedge clk) pe_h <= {pe_h[0], play_enable};
    always @(posedge clk) if (song_done) sd_cnt <= sd_cnt + 1;
    always @(posedge clk) if (load_new_note) ld_cnt <= ld_cnt + 1;

    song_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .next_song        (next_song),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_done        (note_done),
        .play_enable      (play_enable),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done),
        .current_song     (current_song)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_song(input int s, input int marker, input int rest_at);
        logic [5:0] n, d;
        for (int i = 0; i < 32; i++) begin
            n = 6'($urandom_range(0, 63));
            d = 6'($urandom_range(1, 63));
            if (i == rest_at) n = 6'd0;
            if (i == marker)  d = 6'd0;
            rom_mem[7'(s * 32 + i)] = {n, d};
        end
    endtask

    function automatic int song_len(input int s);
        logic [11:0] w;
        for (int i = 0; i < 32; i++) begin
            w = rom_mem[7'(s * 32 + i)];
            if (w[5:0] == 6'd0) return i;
        end
        return 32;
    endfunction

    // Returns ok=1 when the wanted event arrives first, 0 on the other event or timeout.
    task automatic wait_evt(input bit want_load, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_new_note || song_done) begin
                ok = want_load ? load_new_note : song_done;
                return;
            end
        end
    endtask

    task automatic chk_load(input int s, input int k);
        logic [11:0] w;
        w = rom_mem[7'(s * 32 + k)];
        chk("load_note", 32'(note_to_load), 32'(w[11:6]));
        chk("load_dur", 32'(duration_to_load), 32'(w[5:0]));
        chk("load_addr", 32'(rom_addr), 32'(s * 32 + k));
        chk("pe_lead", 32'(pe_h), 32'd3);
        chk("load_pe", 32'(play_enable), 32'd1);
    endtask

    task automatic finish_note(input int s, input int k);
        logic [11:0] w;
        w = rom_mem[7'(s * 32 + k)];
        @(negedge clk);
        chk("strobe_1cyc", 32'(load_new_note), 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk("note_hold", 32'({note_to_load, duration_to_load}), 32'(w));
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
    endtask

    task automatic run_song(input int s, input int start);
        int n;
        bit ok;
        n = song_len(s);
        for (int k = start; k < n; k++) begin
            wait_evt(1'b1, ok);
            chk("load_seen", 32'(ok), 32'd1);
            if (!ok) return;
            chk_load(s, k);
            finish_note(s, k);
        end
        wait_evt(1'b0, ok);
        chk("done_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("end_addr", 32'(rom_addr), 32'(s * 32 + ((n < 32) ? n : 31)));
        chk("end_song", 32'(current_song), 32'(s));
`ifdef SONG_LOOP_EN
        chk("loop_pe", 32'(play_enable), 32'd1);
        @(negedge clk);
        chk("loop_pe2", 32'(play_enable), 32'd1);
        wait_evt(1'b1, ok);
        chk("loop_load", 32'(ok), 32'd1);
        chk("loop_addr", 32'(rom_addr), 32'(s * 32));
`else
        chk("end_pe", 32'(play_enable), 32'd0);
        @(negedge clk);
        chk("done_1cyc", 32'(song_done), 32'd0);
        chk("stop_pe", 32'(play_enable), 32'd0);
`endif
    endtask

    task automatic select_next(input int exp);
        play = 1'b0;
        @(negedge clk);
        @(negedge clk);
        next_song = 1'b1;
        @(negedge clk);
        next_song = 1'b0;
        chk("sel_song", 32'(current_song), 32'(exp));
        chk("sel_pe", 32'(play_enable), 32'd0);
        play = 1'b1;
    endtask

    initial begin
        bit ok;
        int ld0, sd0;
        reset = 1'b1; play = 1'b0; next_song = 1'b0; note_done = 1'b0;
        fill_song(0, 2, -1);
        rom_mem[0] = {6'd12, 6'd2};
        rom_mem[1] = {6'd14, 6'd1};
        fill_song(1, int'($urandom_range(4, 12)), -1);
        fill_song(2, -1, 5);
        fill_song(3, int'($urandom_range(4, 12)), 1);

        #1 reset = 1'b0;
        #1;
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_nd", 32'({note_to_load, duration_to_load}), 32'd0);
        chk("rst_strobes", 32'({load_new_note, song_done, play_enable}), 32'd0);
        chk("rst_song", 32'(current_song), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        play = 1'b1;
        run_song(0, 0);
`ifndef SONG_LOOP_EN
        ld0 = ld_cnt;
        repeat (5) @(negedge clk);
        chk("stopped_hold", 32'(ld_cnt), 32'(ld0));
        chk("stopped_pe", 32'(play_enable), 32'd0);
`endif

        // pause during the second note of song 1, then resume
        select_next(1);
        wait_evt(1'b1, ok); chk("p_load0", 32'(ok), 32'd1);
        chk_load(1, 0); finish_note(1, 0);
        wait_evt(1'b1, ok); chk("p_load1", 32'(ok), 32'd1);
        chk_load(1, 1);
        @(negedge clk);
        play = 1'b0;
        ld0 = ld_cnt;
        @(negedge clk);
        chk("pause_pe", 32'(play_enable), 32'd0);
        repeat (3) @(negedge clk);
        chk("pause_noload", 32'(ld_cnt), 32'(ld0));
        play = 1'b1;
        wait_evt(1'b1, ok); chk("resume_load", 32'(ok), 32'd1);
        chk_load(1, 1); finish_note(1, 1);
        run_song(1, 2);

        select_next(2);
        run_song(2, 0);

        // song change mid-note (coincident note_done is dropped)
        select_next(3);
        wait_evt(1'b1, ok); chk("s3_load0", 32'(ok), 32'd1);
        chk_load(3, 0); finish_note(3, 0);
        wait_evt(1'b1, ok); chk("s3_load1", 32'(ok), 32'd1);
        chk_load(3, 1);
        @(negedge clk);
        sd0 = sd_cnt;
        next_song = 1'b1; note_done = 1'b1;
        @(negedge clk);
        next_song = 1'b0; note_done = 1'b0;
        chk("ns_song", 32'(current_song), 32'd0);
        chk("ns_pe_low", 32'(play_enable), 32'd0);
        chk("ns_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        chk("ns_pe_back", 32'(play_enable), 32'd1);
        chk("ns_no_done", 32'(sd_cnt), 32'(sd0));
        run_song(0, 0);

        // asynchronous reset while a note is playing
        select_next(1);
        wait_evt(1'b1, ok); chk("r_load", 32'(ok), 32'd1);
        chk_load(1, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_outs", 32'({load_new_note, song_done, play_enable}), 32'd0);
        chk("arst_nd", 32'({note_to_load, duration_to_load}), 32'd0);
        chk("arst_addr", 32'({current_song, rom_addr}), 32'd0);
        play = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_idle", 32'(play_enable), 32'd0);
        play = 1'b1;
        wait_evt(1'b1, ok); chk("arst_restart", 32'(ok), 32'd1);
        chk_load(0, 0); finish_note(0, 0);
        run_song(0, 1);

        // randomized song 0 contents
        for (int r = 0; r < 2; r++) begin
            play = 1'b0;
            repeat (2) @(negedge clk);
            fill_song(0, (r == 0) ? int'($urandom_range(1, 10)) : -1, int'($urandom_range(0, 31)));
            play = 1'b1;
            run_song(0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
